uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Next-generation UART receiver: oversampled, majority-voted RX front end feeding a DEPTH-entry
//  first-word-fall-through FIFO with per-entry error flags, sticky overrun and break detection.
//  Sits between the rx pin and the bus peripheral regs. Replaces the single-word uart_receiver.
//  Wire-compatible with uart_transmitter framing via uart_config_t.
// PARAMETERS
//  CLK_FREQ_HZ  1_843_200  clk frequency; baud divisor = CLK_FREQ_HZ/(baud*OVERSAMPLE), truncated
//  OVERSAMPLE   16         samples per bit, even, >=8
//  DEPTH        8          FIFO entries, power of two, >=2
// PORTS
//  clk              in   1         system clock
//  rst_n            in   1         asynchronous active-low reset
//  rx               in   1         serial input, idle high, asynchronous to clk
//  uart_config      in   uart_config_t  baud_rate/data_bits/stop_bits/parity/bit_order
//  rd_en            in   1         pop head entry (ignored when empty)
//  rd_data          out  8         head data, right-justified, unused upper bits 0
//  rd_frame_error   out  1         head entry stop bit sampled low
//  rd_parity_error  out  1         head entry parity mismatch
//  empty            out  1         FIFO empty
//  full             out  1         FIFO full
//  count            out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  overrun          out  1         sticky: frame completed while full and not popped
//  clear_overrun    in   1         clears overrun
//  break_detect     out  1         1-cycle pulse when a break is recognised
// BEHAVIOUR
//  Reset: FIFO empty, count=0, empty=1, full=0, rd_* =0, overrun=0, break_detect=0, FSM=IDLE.
//  rx passes a 2-flop synchroniser (2 cycles latency) before use. Sample tick every divisor clks.
//  Sample value = majority of 3 ticks centred on OVERSAMPLE/2 within each bit.
//  FSM: IDLE -> START on synchronised falling edge; uart_config latched here for whole frame.
//   START: mid-bit vote high -> IDLE (glitch rejected, nothing written); low -> DATA.
//   DATA: 5..8 bits per DATA_BITS_5..8; LSB_FIRST fills bit0 up, MSB_FIRST fills top bit down.
//   PARITY (skipped for PARITY_NONE): EVEN/ODD checked over data bits -> parity_error.
//   STOP: vote at mid of first stop bit; low -> frame_error. STOP_BITS_1_5/2 extra stop time is
//    not checked; FSM returns to IDLE right after first-stop sample (early resync).
//  Break: all data bits 0, parity bit 0 if present, stop vote 0 -> break_detect pulse, no FIFO
//   write, FSM enters BRK_WAIT until synchronised rx high, then IDLE.
//  FIFO write occurs in the cycle after the first-stop mid sample {data, frame_err, parity_err}.
//  FWFT: rd_* reflect head entry whenever !empty; rd_en pops, next entry visible next cycle.
//  rd_en while empty: no effect, rd_* hold. Pointers wrap modulo DEPTH.
//  Write+pop same cycle: both occur, count unchanged; allowed even when full (no overrun).
//  Write while full with no pop: frame dropped, FIFO contents unchanged, overrun<=1.
//  clear_overrun and new overrun same cycle: overrun stays 1 (set wins).
//  uart_config changes mid-frame: ignored until next start bit.
//  rst_n asserted mid-frame: frame discarded, all state to reset values immediately.
// TESTING
//  9600 8-O-1.5 LSB, send 0x72 from uart_transmitter -> rd_data=0x72, errors 0, count=1.
//  Send 0x91 with inverted parity bit -> rd_data=0x91, rd_parity_error=1, rd_frame_error=0.
//  DEPTH=4, send 0x01..0x05 no reads -> full=1, count=4, overrun=1, pops return 0x01..0x04.
//  Full + frame completes with rd_en in write cycle -> no overrun, count stays 4, tail = new byte.
//  Force stop bit low on 0x3C -> rd_frame_error=1; rx low 2 frame times -> one break_detect, count=0.
//  5-E-2 MSB_FIRST send 0x15 -> rd_data=0x15; rx low pulse 0.3 bit -> no entry; reset mid-frame -> empty=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled majority-vote UART receiver feeding a FWFT FIFO with error flags
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   rx                 serial input, idle high, asynchronous to clk
//   uart_config        frame format, latched at each start bit
//   rd_en              pop head entry (ignored when empty)
//   rd_data            head data, right-justified
//   rd_frame_error     head entry stop bit sampled low
//   rd_parity_error    head entry parity mismatch
//   empty, full, count FIFO status
//   overrun            sticky: frame dropped because FIFO was full
//   clear_overrun      clears overrun (a new overrun in the same cycle wins)
//   break_detect       one-cycle pulse on a recognised break
package uart_pkg;
    typedef enum logic [2:0] {BAUD_9600, BAUD_19200, BAUD_38400, BAUD_57600, BAUD_115200} baud_t;
    typedef enum logic [1:0] {DATA_BITS_5, DATA_BITS_6, DATA_BITS_7, DATA_BITS_8} data_bits_t;
    typedef enum logic [1:0] {STOP_BITS_1, STOP_BITS_1_5, STOP_BITS_2} stop_bits_t;
    typedef enum logic [1:0] {PARITY_NONE, PARITY_EVEN, PARITY_ODD} parity_t;
    typedef enum logic {LSB_FIRST, MSB_FIRST} bit_order_t;
    typedef struct packed {
        baud_t      baud_rate;
        data_bits_t data_bits;
        stop_bits_t stop_bits;
        parity_t    parity;
        bit_order_t bit_order;
    } uart_config_t;
endpackage

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 1_843_200,
    parameter int OVERSAMPLE  = 16,
    parameter int DEPTH       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx,
    input  uart_config_t             uart_config,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_frame_error,
    output logic                     rd_parity_error,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    input  logic                     clear_overrun,
    output logic                     break_detect
);
    localparam int AW   = $clog2(DEPTH);
    localparam int SW   = $clog2(OVERSAMPLE);
    localparam int HALF = OVERSAMPLE / 2;

    function automatic int div_of(input int baud);
        int d;
        d = CLK_FREQ_HZ / (baud * OVERSAMPLE);
        return d < 1 ? 1 : d;
    endfunction

    localparam int DIV_W = $clog2(div_of(9600)) + 1;
    localparam logic [DIV_W-1:0] D9600   = DIV_W'(div_of(9600));
    localparam logic [DIV_W-1:0] D19200  = DIV_W'(div_of(19200));
    localparam logic [DIV_W-1:0] D38400  = DIV_W'(div_of(38400));
    localparam logic [DIV_W-1:0] D57600  = DIV_W'(div_of(57600));
    localparam logic [DIV_W-1:0] D115200 = DIV_W'(div_of(115200));

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BRK   = 3'd5;

    logic               r_rx_meta, r_rx_sync, r_rx_prev;
    logic [2:0]         r_state;
    uart_config_t       r_cfg;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [SW-1:0]      r_samp;
    logic               r_v0, r_v1;
    logic [2:0]         r_bit;
    logic [7:0]         r_data;
    logic               r_par, r_par_bit, r_par_err;
    logic               r_wr_pend, r_wr_fe, r_break;
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_overrun;
    logic [9:0]         r_hold;
    logic [9:0]         r_mem [DEPTH];

    logic [DIV_W-1:0]   w_div;
    logic               w_fall, w_tick, w_vote_pt, w_vote, w_last, w_break;
    logic [3:0]         w_nbits;
    logic [2:0]         w_idx;
    logic               w_pop, w_wr_ok;
    logic [9:0]         w_head;
    logic               w_unused;

    // Stop-bit length only matters to the transmitter; extra stop time is not checked here.
    assign w_unused = ^{uart_config.stop_bits, r_cfg.stop_bits};

    assign w_div = r_cfg.baud_rate == BAUD_115200 ? D115200 :
                   r_cfg.baud_rate == BAUD_57600  ? D57600  :
                   r_cfg.baud_rate == BAUD_38400  ? D38400  :
                   r_cfg.baud_rate == BAUD_19200  ? D19200  : D9600;

    assign w_fall    = r_rx_prev & ~r_rx_sync;
    assign w_tick    = r_state != S_IDLE && r_state != S_BRK && r_div_cnt == w_div - DIV_W'(1);
    // Third of the three centred samples; the first two are held in r_v0/r_v1.
    assign w_vote_pt = w_tick && r_samp == SW'(HALF);
    assign w_vote    = (r_v0 & r_v1) | (r_v0 & r_rx_sync) | (r_v1 & r_rx_sync);
    assign w_nbits   = {2'b00, r_cfg.data_bits} + 4'd5;
    assign w_last    = r_bit == 3'(w_nbits - 4'd1);
    assign w_idx     = r_cfg.bit_order == MSB_FIRST ? 3'(w_nbits - 4'd1 - {1'b0, r_bit}) : r_bit;
    assign w_break   = r_data == 8'd0 && !r_par_bit && !w_vote;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_state   <= S_IDLE;
            r_cfg     <= '0;
            r_div_cnt <= '0;
            r_samp    <= '0;
            r_v0      <= 1'b1;
            r_v1      <= 1'b1;
            r_bit     <= '0;
            r_data    <= '0;
            r_par     <= 1'b0;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
            r_wr_pend <= 1'b0;
            r_wr_fe   <= 1'b0;
            r_break   <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_wr_pend <= 1'b0;
            r_break   <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_fall) begin
                    r_state   <= S_START;
                    r_cfg     <= uart_config;
                    r_div_cnt <= '0;
                    r_samp    <= '0;
                    r_bit     <= '0;
                    r_data    <= '0;
                    r_par     <= 1'b0;
                    r_par_bit <= 1'b0;
                    r_par_err <= 1'b0;
                end
            end else if (r_state == S_BRK) begin
                if (r_rx_sync) r_state <= S_IDLE;
            end else begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
                if (w_tick) begin
                    r_samp <= r_samp == SW'(OVERSAMPLE - 1) ? '0 : r_samp + SW'(1);
                    if (r_samp == SW'(HALF - 2)) r_v0 <= r_rx_sync;
                    if (r_samp == SW'(HALF - 1)) r_v1 <= r_rx_sync;
                end
                // State changes happen at mid-bit; the sample counter keeps running so the
                // next decision lands one bit period later.
                if (w_vote_pt) begin
                    case (r_state)
                        S_START: r_state <= w_vote ? S_IDLE : S_DATA;
                        S_DATA: begin
                            r_data[w_idx] <= w_vote;
                            r_par         <= r_par ^ w_vote;
                            r_bit         <= r_bit + 3'd1;
                            if (w_last) r_state <= r_cfg.parity == PARITY_NONE ? S_STOP : S_PAR;
                        end
                        S_PAR: begin
                            r_par_bit <= w_vote;
                            r_par_err <= (r_par ^ w_vote) != (r_cfg.parity == PARITY_ODD);
                            r_state   <= S_STOP;
                        end
                        S_STOP: begin
                            if (w_break) begin
                                r_break <= 1'b1;
                                r_state <= S_BRK;
                            end else begin
                                r_wr_pend <= 1'b1;
                                r_wr_fe   <= !w_vote;
                                r_state   <= S_IDLE;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign empty   = r_count == '0;
    assign full    = r_count == (AW+1)'(DEPTH);
    assign w_pop   = rd_en && !empty;
    // A pop in the write cycle frees the slot, so a full FIFO still accepts the frame.
    assign w_wr_ok = r_wr_pend && (!full || w_pop);

    // r_data/r_par_err are only cleared by a new start, which takes effect after this write.
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= {r_data, r_wr_fe, r_par_err};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_hold    <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count   <= r_count + (AW+1)'(w_wr_ok) - (AW+1)'(w_pop);
            r_overrun <= (r_wr_pend && full && !w_pop) || (r_overrun && !clear_overrun);
            // Remember the last visible head so rd_* hold once the FIFO drains.
            if (!empty) r_hold <= r_mem[r_rd_ptr];
        end
    end

    assign w_head          = empty ? r_hold : r_mem[r_rd_ptr];
    assign rd_data         = w_head[9:2];
    assign rd_frame_error  = w_head[1];
    assign rd_parity_error = w_head[0];
    assign count           = r_count;
    assign overrun         = r_overrun;
    assign break_detect    = r_break;
endmodule
